up_down_counter_mod: RTL and testbench
======================================

// Module: up_down_counter_mod
// PURPOSE
//  Parametrised up/down counter: programmable width, modulus, step size, and wrap or saturate mode.
//  Adds parallel load, count enable, a terminal-count flag, and overflow/underflow pulses.
//  Drop-in successor to the fixed 4-bit up/down counter for timers, address generators and
//  event counters throughout the design.
// PARAMETERS
//  WIDTH     4             counter width in bits (>=2)
//  MAX_VAL   2**WIDTH-1    top of count range; count is always in 0..MAX_VAL (MAX_VAL <= 2**WIDTH-1)
//  SATURATE  0             0 = modulo wrap at range ends, 1 = clamp at 0 / MAX_VAL
// PORTS
//  clk       in   1      clock, all state updates on posedge
//  rst       in   1      synchronous reset, active-high
//  en        in   1      count enable
//  dir       in   1      1 = count up, 0 = count down
//  load      in   1      parallel load strobe
//  load_val  in   WIDTH  value loaded when load=1
//  step      in   WIDTH  increment/decrement amount per enabled cycle
//  count     out  WIDTH  current count (registered)
//  tc        out  1      terminal count (combinational from count, dir)
//  ovf       out  1      registered overflow pulse
//  unf       out  1      registered underflow pulse
// BEHAVIOUR
//  - Priority per posedge: rst > load > en. Counter holds when none is active.
//  - Reset: count=0, ovf=0, unf=0. Reset mid-operation overrides load/en on that edge.
//  - Load: count <= min(load_val, MAX_VAL). ovf=unf=0 on a load cycle.
//  - Latency: an enabled step is sampled at edge N, and the new count is visible after edge N.
//  - Arithmetic:
//    - Compute in WIDTH+1 bits, so no silent truncation.
//    - step is used as min(step, MAX_VAL).
//    - step=0 with en=1: hold, no flags.
//  - Up (dir=1), sum = count+step:
//    - sum <= MAX_VAL: count <= sum, ovf=0.
//    - sum > MAX_VAL, SATURATE=0: count <= sum-(MAX_VAL+1), ovf=1.
//    - sum > MAX_VAL, SATURATE=1: count <= MAX_VAL, ovf=1.
//  - Down (dir=0), step > count:
//    - SATURATE=0: count <= count+(MAX_VAL+1)-step, unf=1.
//    - SATURATE=1: count <= 0, unf=1.
//    - otherwise: count <= count-step, unf=0.
//  - ovf/unf are high for exactly the cycle following each clipping/wrapping edge.
//    - In saturate mode they stay high on every further enabled step that pushes past the limit.
//    - Both are 0 whenever en=0, load=1 or rst=1.
//  - tc = (dir & count==MAX_VAL) | (~dir & count==0). Follows dir changes immediately,
//    even with en=0.
//  - dir change takes effect on the next enabled edge; no intermediate hold cycle.
//  - Never drives count > MAX_VAL under any input combination.
// TESTING
//  1. WIDTH=4 defaults; rst 2 cycles, then en=1 dir=1 step=1
//     -> count 0,1,..,15,0; tc=1 while count=15; ovf=1 only in the cycle after 15->0.
//  2. From count=0, dir=0 step=1 en=1 -> count 15,14,..; unf=1 only after the 0->15 edge;
//     tc=1 while count=0 with dir=0.
//  3. MAX_VAL=9, SATURATE=0, load 8, step=3 up -> count 1, ovf=1.
//     Same with SATURATE=1 -> 9,9,9 with ovf=1 each enabled cycle.
//  4. MAX_VAL=9: load=1 en=1 load_val=12 same edge -> count=9 (load wins, clamped), ovf=unf=0.
//  5. Counting up at count=6, assert rst with load=1 load_val=3 -> count=0, ovf=unf=0 next cycle;
//     resumes 1,2,.. after rst drops.
//  6. en=0 while toggling dir and step -> count holds, ovf=unf=0, tc tracks dir.

Source files
------------

// File: rtl/up_down_counter_mod.sv
// -----------------------------------------------------------------------------
// up_down_counter_mod
//   Parametrised up/down counter with programmable width, modulus (MAX_VAL),
//   per-cycle step size and wrap-or-saturate behaviour at the range ends.
//   Supports parallel load, count enable, a terminal-count flag, and
//   single-cycle overflow/underflow pulses.
//
//   Priority on each rising edge: rst > load > en; otherwise the counter holds.
//   The count never leaves 0..MAX_VAL. This holds even if load_val or step
//   exceed MAX_VAL, because both are clamped first.
//
// Parameters
//   WIDTH     counter width in bits (>= 2)
//   MAX_VAL   top of the count range (<= 2**WIDTH-1)
//   SATURATE  0 = modulo wrap at the range ends, 1 = clamp at 0 / MAX_VAL
//
// Ports
//   clk       clock; all state updates on posedge
//   rst       synchronous reset, active-high
//   en        count enable
//   dir       1 = count up, 0 = count down
//   load      parallel load strobe
//   load_val  value loaded when load=1 (clamped to MAX_VAL)
//   step      amount added/subtracted per enabled cycle (clamped to MAX_VAL)
//   count     current count (registered)
//   tc        terminal count; combinational from count and dir
//   ovf       registered overflow pulse
//   unf       registered underflow pulse
// -----------------------------------------------------------------------------
module up_down_counter_mod #(
  parameter int WIDTH    = 4,
  parameter int MAX_VAL  = 2**WIDTH-1,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] step,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             ovf,
  output logic             unf
);

  localparam logic [WIDTH-1:0] MAX_V      = WIDTH'(MAX_VAL);
  // The modulus needs one more bit than the count when the range is full.
  localparam logic [WIDTH:0]   MOD        = (WIDTH+1)'(MAX_VAL + 1);
  localparam bit               FULL_RANGE = (MAX_VAL == 2**WIDTH-1);

  logic [WIDTH-1:0] step_eff;
  logic [WIDTH-1:0] load_eff;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] wrap_up;
  logic [WIDTH-1:0] wrap_dn;
  logic [WIDTH-1:0] next_count;
  logic             next_ovf;
  logic             next_unf;

  // With a full-width range, no input value can exceed MAX_VAL. The clamp is
  // therefore only built for a reduced modulus.
  generate
    if (FULL_RANGE) begin : g_no_clamp
      assign step_eff = step;
      assign load_eff = load_val;
    end else begin : g_clamp
      assign step_eff = (step     > MAX_V) ? MAX_V : step;
      assign load_eff = (load_val > MAX_V) ? MAX_V : load_val;
    end
  endgenerate

  // The up sum is formed one bit wider than the count, so a crossing of
  // MAX_VAL is always visible. The wrapped results always land back in
  // 0..MAX_VAL, so truncating them to WIDTH bits is exact.
  assign sum     = {1'b0, count} + {1'b0, step_eff};
  assign wrap_up = WIDTH'(sum - MOD);
  assign wrap_dn = WIDTH'({1'b0, count} + MOD - {1'b0, step_eff});

  assign tc = dir ? (count == MAX_V) : (count == '0);

  always_comb begin
    // NOTE: every output of this block gets a default before any branch. This
    // keeps the logic purely combinational, so no latch is inferred.
    next_count = count;
    next_ovf   = 1'b0;
    next_unf   = 1'b0;
    if (load) begin
      next_count = load_eff;
    end else if (en) begin
      if (dir) begin
        if (sum > {1'b0, MAX_V}) begin
          next_ovf   = 1'b1;
          next_count = SATURATE ? MAX_V : wrap_up;
        end else begin
          next_count = WIDTH'(sum);
        end
      end else begin
        if (step_eff > count) begin
          next_unf   = 1'b1;
          next_count = SATURATE ? '0 : wrap_dn;
        end else begin
          next_count = count - step_eff;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments. All registers
    // therefore sample their inputs from before the edge, with no race
    // between flops.
    if (rst) begin
      count <= '0;
      ovf   <= 1'b0;
      unf   <= 1'b0;
    end else begin
      count <= next_count;
      ovf   <= next_ovf;
      unf   <= next_unf;
    end
  end

endmodule

// File: tb/tb_up_down_counter_mod.sv
// -----------------------------------------------------------------------------
// tb_up_down_counter_mod
//   Drives three counter configurations from the same stimulus:
//     inst 0: WIDTH=4, MAX_VAL=15, wrap
//     inst 1: WIDTH=4, MAX_VAL=9,  wrap
//     inst 2: WIDTH=4, MAX_VAL=9,  saturate
//   An integer reference model tracks the expected count and flags for each
//   instance. Outputs are sampled 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_up_down_counter_mod;

  localparam int W = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, en, dir, load;
  logic [W-1:0] load_val, step;

  logic [2:0][W-1:0] cnt_o;
  logic [2:0]        tc_o, ovf_o, unf_o;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  int maxv[3] = '{15, 9, 9};
  bit satv[3] = '{1'b0, 1'b0, 1'b1};

  int m_cnt[3] = '{0, 0, 0};
  bit m_ovf[3] = '{1'b0, 1'b0, 1'b0};
  bit m_unf[3] = '{1'b0, 1'b0, 1'b0};

  up_down_counter_mod #(.WIDTH(W)) u0 (
    .clk(clk), .rst(rst), .en(en), .dir(dir), .load(load),
    .load_val(load_val), .step(step),
    .count(cnt_o[0]), .tc(tc_o[0]), .ovf(ovf_o[0]), .unf(unf_o[0])
  );

  up_down_counter_mod #(.WIDTH(W), .MAX_VAL(9), .SATURATE(1'b0)) u1 (
    .clk(clk), .rst(rst), .en(en), .dir(dir), .load(load),
    .load_val(load_val), .step(step),
    .count(cnt_o[1]), .tc(tc_o[1]), .ovf(ovf_o[1]), .unf(unf_o[1])
  );

  up_down_counter_mod #(.WIDTH(W), .MAX_VAL(9), .SATURATE(1'b1)) u2 (
    .clk(clk), .rst(rst), .en(en), .dir(dir), .load(load),
    .load_val(load_val), .step(step),
    .count(cnt_o[2]), .tc(tc_o[2]), .ovf(ovf_o[2]), .unf(unf_o[2])
  );

  // Reference model: applies one clock edge of the behavioural rules to every
  // instance, using plain integer arithmetic.
  task automatic model_edge();
    for (int k = 0; k < 3; k++) begin
      int s;
      int t;
      m_ovf[k] = 1'b0;
      m_unf[k] = 1'b0;
      if (rst) begin
        m_cnt[k] = 0;
      end else if (load) begin
        m_cnt[k] = (int'(load_val) > maxv[k]) ? maxv[k] : int'(load_val);
      end else if (en) begin
        s = (int'(step) > maxv[k]) ? maxv[k] : int'(step);
        if (dir) begin
          t = m_cnt[k] + s;
          if (t > maxv[k]) begin
            m_ovf[k] = 1'b1;
            m_cnt[k] = satv[k] ? maxv[k] : t - (maxv[k] + 1);
          end else begin
            m_cnt[k] = t;
          end
        end else if (s > m_cnt[k]) begin
          m_unf[k] = 1'b1;
          m_cnt[k] = satv[k] ? 0 : m_cnt[k] + maxv[k] + 1 - s;
        end else begin
          m_cnt[k] = m_cnt[k] - s;
        end
      end
    end
  endtask

  // Expected {count, ovf, unf, tc}; tc uses the dir currently being driven.
  function automatic logic [6:0] expected(input int k);
    logic exp_tc;
    exp_tc = dir ? (m_cnt[k] == maxv[k]) : (m_cnt[k] == 0);
    return {W'(m_cnt[k]), m_ovf[k], m_unf[k], exp_tc};
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge();
    cyc++;
    #1;
  endtask

  task automatic test_reset();
    logic [6:0] got, exp;
    rst = 1'b1; en = 1'b1; dir = 1'b1; load = 1'b1; load_val = 4'd5; step = 4'd1;
    for (int i = 0; i < 2; i++) begin
      tick();
      for (int k = 0; k < 3; k++) begin
        exp = expected(k);
        got = {cnt_o[k], ovf_o[k], unf_o[k], tc_o[k]};
        checks++;
        if (got !== exp) begin
          errors++;
          $display("FAIL reset inst%0d cyc%0d: got cnt=%0d ovf=%b unf=%b tc=%b want cnt=%0d ovf=%b unf=%b tc=%b",
                   k, cyc, got[6:3], got[2], got[1], got[0], exp[6:3], exp[2], exp[1], exp[0]);
        end
      end
    end
    rst = 1'b0; load = 1'b0;
  endtask

  task automatic test_count_up();
    logic [6:0] got, exp;
    en = 1'b1; dir = 1'b1; step = 4'd1;
    for (int i = 0; i < 17; i++) begin
      tick();
      for (int k = 0; k < 3; k++) begin
        exp = expected(k);
        got = {cnt_o[k], ovf_o[k], unf_o[k], tc_o[k]};
        checks++;
        if (got !== exp) begin
          errors++;
          $display("FAIL count_up inst%0d cyc%0d: got cnt=%0d ovf=%b unf=%b tc=%b want cnt=%0d ovf=%b unf=%b tc=%b",
                   k, cyc, got[6:3], got[2], got[1], got[0], exp[6:3], exp[2], exp[1], exp[0]);
        end
      end
    end
  endtask

  task automatic test_count_down();
    logic [6:0] got, exp;
    // Load 0 everywhere, then count down through the wrap/clamp at 0.
    load = 1'b1; load_val = 4'd0;
    tick();
    load = 1'b0; en = 1'b1; dir = 1'b0; step = 4'd1;
    for (int i = 0; i < 12; i++) begin
      tick();
      for (int k = 0; k < 3; k++) begin
        exp = expected(k);
        got = {cnt_o[k], ovf_o[k], unf_o[k], tc_o[k]};
        checks++;
        if (got !== exp) begin
          errors++;
          $display("FAIL count_down inst%0d cyc%0d: got cnt=%0d ovf=%b unf=%b tc=%b want cnt=%0d ovf=%b unf=%b tc=%b",
                   k, cyc, got[6:3], got[2], got[1], got[0], exp[6:3], exp[2], exp[1], exp[0]);
        end
      end
    end
  endtask

  task automatic test_wrap_saturate();
    logic [6:0] got, exp;
    load = 1'b1; load_val = 4'd8; en = 1'b0;
    tick();
    load = 1'b0; en = 1'b1; dir = 1'b1; step = 4'd3;
    for (int i = 0; i < 4; i++) begin
      tick();
      for (int k = 0; k < 3; k++) begin
        exp = expected(k);
        got = {cnt_o[k], ovf_o[k], unf_o[k], tc_o[k]};
        checks++;
        if (got !== exp) begin
          errors++;
          $display("FAIL wrap_sat inst%0d cyc%0d: got cnt=%0d ovf=%b unf=%b tc=%b want cnt=%0d ovf=%b unf=%b tc=%b",
                   k, cyc, got[6:3], got[2], got[1], got[0], exp[6:3], exp[2], exp[1], exp[0]);
        end
      end
    end
  endtask

  task automatic test_load_clamp();
    logic [6:0] got, exp;
    // Load beats an enabled up-step on the same edge, then load_val is clamped.
    load = 1'b1; en = 1'b1; dir = 1'b1; step = 4'd3; load_val = 4'd12;
    tick();
    load = 1'b0; en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      exp = expected(k);
      got = {cnt_o[k], ovf_o[k], unf_o[k], tc_o[k]};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL load_clamp inst%0d cyc%0d: got cnt=%0d ovf=%b unf=%b tc=%b want cnt=%0d ovf=%b unf=%b tc=%b",
                 k, cyc, got[6:3], got[2], got[1], got[0], exp[6:3], exp[2], exp[1], exp[0]);
      end
    end
  endtask

  task automatic test_reset_priority();
    logic [6:0] got, exp;
    rst = 1'b1;
    tick();
    rst = 1'b0; en = 1'b1; dir = 1'b1; step = 4'd1;
    repeat (6) tick();
    // Reset at the same edge as load and enable: reset must win.
    rst = 1'b1; load = 1'b1; load_val = 4'd3;
    for (int i = 0; i < 4; i++) begin
      tick();
      rst = 1'b0; load = 1'b0;
      for (int k = 0; k < 3; k++) begin
        exp = expected(k);
        got = {cnt_o[k], ovf_o[k], unf_o[k], tc_o[k]};
        checks++;
        if (got !== exp) begin
          errors++;
          $display("FAIL rst_prio inst%0d cyc%0d: got cnt=%0d ovf=%b unf=%b tc=%b want cnt=%0d ovf=%b unf=%b tc=%b",
                   k, cyc, got[6:3], got[2], got[1], got[0], exp[6:3], exp[2], exp[1], exp[0]);
        end
      end
    end
  endtask

  task automatic test_hold();
    logic [6:0] got, exp;
    en = 1'b0; load = 1'b0; rst = 1'b0;
    tick();
    for (int i = 0; i < 8; i++) begin
      // tc must follow a dir change between edges, with no clock.
      dir  = ~dir;
      step = W'($urandom_range(0, 15));
      #1;
      for (int k = 0; k < 3; k++) begin
        exp = expected(k);
        got = {cnt_o[k], ovf_o[k], unf_o[k], tc_o[k]};
        checks++;
        if (got !== exp) begin
          errors++;
          $display("FAIL hold inst%0d cyc%0d: got cnt=%0d ovf=%b unf=%b tc=%b want cnt=%0d ovf=%b unf=%b tc=%b",
                   k, cyc, got[6:3], got[2], got[1], got[0], exp[6:3], exp[2], exp[1], exp[0]);
        end
      end
      tick();
    end
  endtask

  task automatic test_random();
    logic [6:0] got, exp;
    for (int i = 0; i < 400; i++) begin
      rst      = ($urandom_range(0, 49) == 0);
      load     = ($urandom_range(0, 9) == 0);
      en       = ($urandom_range(0, 3) != 0);
      dir      = 1'($urandom);
      step     = ($urandom_range(0, 5) == 0) ? '0 : W'($urandom_range(0, 15));
      load_val = W'($urandom_range(0, 15));
      tick();
      for (int k = 0; k < 3; k++) begin
        exp = expected(k);
        got = {cnt_o[k], ovf_o[k], unf_o[k], tc_o[k]};
        checks++;
        if (got !== exp) begin
          errors++;
          $display("FAIL random inst%0d cyc%0d: got cnt=%0d ovf=%b unf=%b tc=%b want cnt=%0d ovf=%b unf=%b tc=%b",
                   k, cyc, got[6:3], got[2], got[1], got[0], exp[6:3], exp[2], exp[1], exp[0]);
        end
      end
    end
    rst = 1'b0; load = 1'b0; en = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; dir = 1'b1; load = 1'b0; load_val = '0; step = '0;
    test_reset();
    test_count_up();
    test_count_down();
    test_wrap_saturate();
    test_load_clamp();
    test_reset_priority();
    test_hold();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
